reg_bank_fs: RTL

Parametrised bank of NUM_REGS general-purpose registers, each WIDTH bits, sharing one data input and one function-select bus, with two combinational read ports. It succeeds the single 16-bit FunSel register in the datapath and is used for the CPU's general-purpose and address register groups. It extends the operation set with shifts and rotates, allows multi-register writes in one cycle, and adds a registered wrap flag for counter overflow and underflow.

---
 rtl/reg_bank_fs.sv | 81 ++++++++
 1 files changed

// File: rtl/reg_bank_fs.sv
// Bank of NUM_REGS registers sharing one load bus and one function select,
// with two combinational read ports and a registered counter-wrap pulse.
module reg_bank_fs #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 4,
  localparam int SW      = $clog2(NUM_REGS),
  localparam int HALF    = WIDTH / 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [WIDTH-1:0]    I,
  input  logic [NUM_REGS-1:0] E,
  input  logic [3:0]          FunSel,
  input  logic [SW-1:0]       OutASel,
  input  logic [SW-1:0]       OutBSel,
  output logic [WIDTH-1:0]    OutA,
  output logic [WIDTH-1:0]    OutB,
  output logic                Wrap
);

  logic [WIDTH-1:0]    regs_reg  [NUM_REGS];
  logic [WIDTH-1:0]    regs_next [NUM_REGS];
  logic [NUM_REGS-1:0] wrap_vec;
  logic                wrap_reg;
  logic [HALF-1:0]     lo;

  assign lo = I[HALF-1:0];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [WIDTH-1:0] cur;
      assign cur = regs_reg[gi];

      always_comb begin
        regs_next[gi] = cur;
        case (FunSel)
          4'b0000: regs_next[gi] = cur - WIDTH'(1);
          4'b0001: regs_next[gi] = cur + WIDTH'(1);
          4'b0010: regs_next[gi] = I;
          4'b0011: regs_next[gi] = '0;
          4'b0100: regs_next[gi] = {{HALF{1'b0}}, lo};
          4'b0101: regs_next[gi] = {cur[WIDTH-1:HALF], lo};
          4'b0110: regs_next[gi] = {lo, cur[HALF-1:0]};
          4'b0111: regs_next[gi] = {{HALF{lo[HALF-1]}}, lo};
          4'b1000: regs_next[gi] = {cur[WIDTH-2:0], 1'b0};
          4'b1001: regs_next[gi] = {1'b0, cur[WIDTH-1:1]};
          4'b1010: regs_next[gi] = {cur[WIDTH-1], cur[WIDTH-1:1]};
          4'b1011: regs_next[gi] = {cur[WIDTH-2:0], cur[WIDTH-1]};
          4'b1100: regs_next[gi] = {cur[0], cur[WIDTH-1:1]};
          default: regs_next[gi] = cur;
        endcase
      end

      // Wrap looks at the pre-edge value, so it flags the edge that overflows.
      assign wrap_vec[gi] = E[gi] &&
                            (((FunSel == 4'b0001) && (&cur)) ||
                             ((FunSel == 4'b0000) && (cur == '0)));

      always_ff @(posedge Clock) begin
        if (Reset) begin
          regs_reg[gi] <= '0;
        end else if (E[gi]) begin
          regs_reg[gi] <= regs_next[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= |wrap_vec;
    end
  end

  assign OutA = regs_reg[OutASel];
  assign OutB = regs_reg[OutBSel];
  assign Wrap = wrap_reg;

endmodule
